ser_tx: RTL and testbench

Parallel-to-serial frame transmitter. It is the driving end for a serial line sampled by an edge-triggered D flip-flop receiver chain.
- Accepts one DW-bit word on a load strobe.
- Emits a frame on sout: start bit, DW data bits LSB first, parity bit, stop bit.
- Each bit is held for DIV clocks.
- Reports busy while a frame is in flight and pulses done when the frame completes.

---
 rtl/ser_tx_if.sv | 27 ++
 rtl/ser_tx.sv | 112 +++++++++++
 tb/tb_ser_tx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ser_tx_if.sv
// Handshake bundle between a word source and the ser_tx frame transmitter.
// The source drives load/din; the transmitter drives the serial line and status.
interface ser_tx_if #(
    parameter int DW = 8
);
    logic          load;
    logic [DW-1:0] din;
    logic          sout;
    logic          busy;
    logic          done;

    modport master (
        output load,
        output din,
        input  sout,
        input  busy,
        input  done
    );

    modport slave (
        input  load,
        input  din,
        output sout,
        output busy,
        output done
    );
endinterface

// File: rtl/ser_tx.sv
// Parallel-to-serial frame transmitter: start bit, DW data bits LSB first,
// parity bit, stop bit, each held for DIV clocks. All outputs are registered.
module ser_tx #(
    parameter int DW  = 8,
    parameter int DIV = 4,
    parameter int ODD = 0
) (
    input  logic    clk,
    input  logic    rst_n,
    ser_tx_if.slave bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [DW-1:0] shift;
    logic          parity;
    logic          sout_q;
    logic          busy_q;
    logic          done_q;

    logic          bit_end;
    logic [DW-1:0] shift_nxt;

    assign bit_end   = (div_cnt == CW'(DIV - 1));
    assign shift_nxt = shift >> 1;

    assign bus.sout = sout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    // NOTE: every register, including the shift register, gets an async reset
    // and is updated with <= so all state samples pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            parity  <= 1'b0;
            sout_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Divide counter free-runs through every non-idle bit period.
            if (state != IDLE) begin
                div_cnt <= bit_end ? '0 : div_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.load) begin
                        shift   <= bus.din;
                        parity  <= (^bus.din) ^ (ODD != 0);
                        state   <= START;
                        sout_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        div_cnt <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        sout_q  <= shift[0];
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == BW'(DW - 1)) begin
                            state  <= PAR;
                            sout_q <= parity;
                        end else begin
                            shift   <= shift_nxt;
                            sout_q  <= shift_nxt[0];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (bit_end) begin
                        state  <= STOP;
                        sout_q <= 1'b1;
                    end
                end
                STOP: begin
                    // load on this edge is ignored; the next frame starts one idle clock later.
                    if (bit_end) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ser_tx.sv
// Self-checking bench for ser_tx: three instances (even/DIV=4, odd/DIV=4,
// even/DIV=1) checked clock by clock against a per-bit frame model.
module tb_ser_tx;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] load_v;
    logic [7:0] din_v [3];
    logic [2:0] sout_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;

    const int DIVS [3] = '{4, 4, 1};
    const int ODDS [3] = '{0, 1, 0};

    ser_tx_if #(.DW(8)) bus_e ();
    ser_tx_if #(.DW(8)) bus_o ();
    ser_tx_if #(.DW(8)) bus_f ();

    assign bus_e.load = load_v[0];
    assign bus_e.din  = din_v[0];
    assign sout_v[0]  = bus_e.sout;
    assign busy_v[0]  = bus_e.busy;
    assign done_v[0]  = bus_e.done;

    assign bus_o.load = load_v[1];
    assign bus_o.din  = din_v[1];
    assign sout_v[1]  = bus_o.sout;
    assign busy_v[1]  = bus_o.busy;
    assign done_v[1]  = bus_o.done;

    assign bus_f.load = load_v[2];
    assign bus_f.din  = din_v[2];
    assign sout_v[2]  = bus_f.sout;
    assign busy_v[2]  = bus_f.busy;
    assign done_v[2]  = bus_f.done;

    ser_tx #(.DW(8), .DIV(4), .ODD(0)) u_even (.clk(clk), .rst_n(rst_n), .bus(bus_e));
    ser_tx #(.DW(8), .DIV(4), .ODD(1)) u_odd  (.clk(clk), .rst_n(rst_n), .bus(bus_o));
    ser_tx #(.DW(8), .DIV(1), .ODD(0)) u_fast (.clk(clk), .rst_n(rst_n), .bus(bus_f));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level of each serial bit: start, data LSB first, parity, stop.
    function automatic void frame_bits(input logic [7:0] d, input int odd, output logic bits [11]);
        int ones;
        ones    = 0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bits[1 + i] = ((d >> i) & 8'd1) != 0;
            ones += int'((d >> i) & 8'd1);
        end
        bits[9]  = ((ones + odd) % 2) == 1;
        bits[10] = 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_idle(input int k, input string tag);
        check($sformatf("%s u%0d sout", tag, k), 32'(sout_v[k]), 32'd1);
        check($sformatf("%s u%0d busy", tag, k), 32'(busy_v[k]), 32'd0);
        check($sformatf("%s u%0d done", tag, k), 32'(done_v[k]), 32'd0);
    endtask

    // Sends one frame on instance k and checks every clock up to the done edge.
    // inj_at >= 0 raises load with inj_d during that clock of the frame.
    // hold leaves load asserted so the next call's first edge is the re-accept.
    task automatic send_frame(input int k, input logic [7:0] d, input int inj_at,
                              input logic [7:0] inj_d, input bit hold, output int done_cyc);
        logic bits [11];
        int   n;
        frame_bits(d, ODDS[k], bits);
        n         = 11 * DIVS[k];
        load_v[k] = 1'b1;
        din_v[k]  = d;
        tick();
        if (!hold) load_v[k] = 1'b0;
        din_v[k] = 8'($urandom);
        for (int e = 0; e < n; e++) begin
            check($sformatf("u%0d d=%h sout e%0d", k, d, e), 32'(sout_v[k]), 32'(bits[e / DIVS[k]]));
            check($sformatf("u%0d d=%h busy e%0d", k, d, e), 32'(busy_v[k]), 32'd1);
            check($sformatf("u%0d d=%h done e%0d", k, d, e), 32'(done_v[k]), 32'd0);
            if (e == inj_at) begin
                load_v[k] = 1'b1;
                din_v[k]  = inj_d;
            end else if (!hold) begin
                load_v[k] = 1'b0;
            end
            tick();
        end
        check($sformatf("u%0d d=%h end sout", k, d), 32'(sout_v[k]), 32'd1);
        check($sformatf("u%0d d=%h end busy", k, d), 32'(busy_v[k]), 32'd0);
        check($sformatf("u%0d d=%h end done", k, d), 32'(done_v[k]), 32'd1);
        done_cyc = cyc;
    endtask

    initial begin
        int dc1;
        int dc2;
        load_v = '0;
        for (int k = 0; k < 3; k++) din_v[k] = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check_idle(k, "reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reference frame, then parity polarity on both instances.
        send_frame(0, 8'hA5, -1, 8'h00, 1'b0, dc1);
        tick();
        check_idle(0, "post A5");
        send_frame(0, 8'h07, -1, 8'h00, 1'b0, dc1);
        tick();
        send_frame(1, 8'h07, -1, 8'h00, 1'b0, dc1);
        tick();

        // A load during a frame is ignored and produces no second frame.
        send_frame(0, 8'h3C, 10, 8'hFF, 1'b0, dc1);
        for (int c = 0; c < 6; c++) begin
            tick();
            check_idle(0, $sformatf("no-refire c%0d", c));
        end

        // Back-to-back with load held high: one idle clock, done pulses 45 apart.
        send_frame(0, 8'h55, -1, 8'h00, 1'b1, dc1);
        send_frame(0, 8'h55, -1, 8'h00, 1'b1, dc2);
        check("b2b done spacing", 32'(dc2 - dc1), 32'd45);
        load_v[0] = 1'b0;
        tick();
        tick();
        check_idle(0, "post b2b");

        // Asynchronous reset mid-DATA aborts the frame with no done pulse.
        load_v[0] = 1'b1;
        din_v[0]  = 8'hA5;
        tick();
        load_v[0] = 1'b0;
        for (int e = 0; e < 17; e++) tick();
        check("pre-abort busy", 32'(busy_v[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_idle(0, "abort");
        tick();
        check_idle(0, "abort held");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_idle(0, $sformatf("post-abort c%0d", c));
        end
        send_frame(0, 8'(($urandom)), -1, 8'h00, 1'b0, dc1);
        tick();

        // Single-clock bit period.
        send_frame(2, 8'h80, -1, 8'h00, 1'b0, dc1);
        tick();
        check_idle(2, "post fast");

        // Random words across all three configurations.
        for (int i = 0; i < 9; i++) begin
            send_frame(i % 3, 8'($urandom), -1, 8'h00, 1'b0, dc1);
            tick();
            check_idle(i % 3, $sformatf("rand %0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
